// File: rtl/pwm_duty_ramp_if.sv
// pwm_duty_ramp_if: signal bundle between the duty switch bank and the PWM conditioning stage
// Ports (slave = conditioning stage, master = switch side / consumer):
//   sw_duty  [6:0] raw asynchronous switch value, percent
//   duty_out [6:0] registered, slewed duty cycle, 0..100
//   target   [6:0] last accepted, clamped switch value
//   busy           high while duty_out != target
//   accept         one-cycle pulse when a new target is latched
interface pwm_duty_ramp_if;
    logic [6:0] sw_duty;
    logic [6:0] duty_out;
    logic [6:0] target;
    logic       busy;
    logic       accept;
    modport master (output sw_duty, input duty_out, target, busy, accept);
    modport slave  (input sw_duty, output duty_out, target, busy, accept);
endinterface

// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp: synchronise, debounce and clamp the duty switches, then slew duty_out toward the target
// Ports:
//   clk    system clock, all state on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    pwm_duty_ramp_if.slave (sw_duty in; duty_out, target, busy, accept out)
// Parameters: DEBOUNCE_CYCLES (>=2) stable cycles before acceptance, STEP_CYCLES (>=1) cycles per ramp step
// Macro PWM_DUTY_RAMP_EN: when defined, duty_out ramps one percent per STEP_CYCLES;
// otherwise duty_out simply follows target one cycle after accept.
module pwm_duty_ramp #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int STEP_CYCLES     = 100_000
) (
    input  logic           clk,
    input  logic           rst_n,
    pwm_duty_ramp_if.slave bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    function automatic logic [6:0] clamp(input logic [6:0] v);
        return v > 7'd100 ? 7'd100 : v;
    endfunction

    logic [6:0]    meta_q, meta_d, sync_q, sync_d, cand_q, cand_d, cand_clamp;
    logic [DW-1:0] db_cnt_q, db_cnt_d;
    logic [6:0]    target_q, target_d, duty_q, duty_d;
    logic          accept_q, accept_d;

    always_comb begin
        meta_d     = bus.sw_duty;
        sync_d     = meta_q;
        cand_clamp = clamp(cand_q);
        cand_d     = cand_q;
        db_cnt_d   = db_cnt_q;
        target_d   = target_q;
        accept_d   = 1'b0;
        if (sync_q != cand_q) begin
            cand_d   = sync_q;
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            // counter parks at the terminal value; only a real change of target pulses accept
            target_d = cand_clamp != target_q ? cand_clamp : target_q;
            accept_d = cand_clamp != target_q;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

`ifdef PWM_DUTY_RAMP_EN
    localparam int SW = STEP_CYCLES > 1 ? $clog2(STEP_CYCLES) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RAMP = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [SW-1:0] step_cnt_q, step_cnt_d;
    logic [6:0]    duty_step;

    // direction is re-evaluated every step so a target change mid-ramp can reverse it
    always_comb begin
        state_d    = state_q;
        step_cnt_d = step_cnt_q;
        duty_d     = duty_q;
        duty_step  = target_q > duty_q ? duty_q + 7'd1 : duty_q - 7'd1;
        if (state_q == S_IDLE) begin
            step_cnt_d = '0;
            state_d    = target_q != duty_q ? S_RAMP : S_IDLE;
        end else if (target_q == duty_q) begin
            state_d    = S_IDLE;
            step_cnt_d = '0;
        end else if (step_cnt_q == STEP_LAST) begin
            duty_d     = duty_step;
            step_cnt_d = '0;
            state_d    = duty_step == target_q ? S_IDLE : S_RAMP;
        end else begin
            step_cnt_d = step_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            step_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
        end
    end
`else
    always_comb duty_d = target_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q   <= '0;
            sync_q   <= '0;
            cand_q   <= '0;
            db_cnt_q <= '0;
            target_q <= '0;
            accept_q <= 1'b0;
            duty_q   <= '0;
        end else begin
            meta_q   <= meta_d;
            sync_q   <= sync_d;
            cand_q   <= cand_d;
            db_cnt_q <= db_cnt_d;
            target_q <= target_d;
            accept_q <= accept_d;
            duty_q   <= duty_d;
        end
    end

    assign bus.duty_out = duty_q;
    assign bus.target   = target_q;
    assign bus.accept   = accept_q;
    assign bus.busy     = duty_q != target_q;
endmodule

// File: tb/tb_pwm_duty_ramp.sv
// tb_pwm_duty_ramp: directed checks of reset, debounce latency, bounce rejection, clamp, reversal and async reset
module tb_pwm_duty_ramp;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_vec = 0;
    int n_bad = 0;

`ifdef PWM_DUTY_RAMP_EN
    localparam bit RAMP = 1'b1;
`else
    localparam bit RAMP = 1'b0;
`endif

    pwm_duty_ramp_if bus ();

    pwm_duty_ramp #(
        .DEBOUNCE_CYCLES(4),
        .STEP_CYCLES    (3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_accept(input int limit, output int cyc);
        cyc = 0;
        while (bus.accept !== 1'b1 && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        check("accept_seen", bus.accept, 1);
    endtask

    task automatic wait_idle(input int limit);
        int cyc = 0;
        while (bus.busy !== 1'b0 && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        check("idle_reached", bus.busy, 0);
    endtask

    task automatic wait_duty(input logic [6:0] v, input int limit);
        int cyc = 0;
        while (bus.duty_out !== v && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        check("duty_reached", bus.duty_out, v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cyc, acc_cnt, jumps, bcnt;
        logic [6:0] prev, dmax, dmin;
        // reset held with switches at 50
        bus.sw_duty = 7'd50;
        repeat (3) @(negedge clk);
        check("rst_duty", bus.duty_out, 0);
        check("rst_target", bus.target, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_accept", bus.accept, 0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("acc_lat6", bus.accept, 0);
        @(negedge clk);
        check("acc_lat7", bus.accept, 1);
        check("acc_target", bus.target, 50);
        check("acc_busy", bus.busy, 1);
        check("acc_duty_lag", bus.duty_out, 0);
        @(negedge clk);
        check("acc_pulse", bus.accept, 0);
        check("follow_duty", bus.duty_out, RAMP ? 0 : 50);
        check("follow_busy", bus.busy, RAMP ? 1 : 0);
`ifdef PWM_DUTY_RAMP_EN
        repeat (2) @(negedge clk);
        check("first_step_pre", bus.duty_out, 0);
        @(negedge clk);
        check("first_step", bus.duty_out, 1);
        wait_idle(200);
        check("ramp50_duty", bus.duty_out, 50);
`endif
        // bounce between 20 and 21 every 2 cycles for 40 cycles
        acc_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            bus.sw_duty = i[0] ? 7'd21 : 7'd20;
            repeat (2) begin
                @(negedge clk);
                acc_cnt += int'(bus.accept);
            end
        end
        check("bounce_no_acc", acc_cnt, 0);
        check("bounce_target", bus.target, 50);
        bus.sw_duty = 7'd20;
        wait_accept(20, cyc);
        check("bounce_lat", cyc, 7);
        check("bounce_new_target", bus.target, 20);
        wait_idle(200);
        check("bounce_duty", bus.duty_out, 20);
        // clamp 127 -> 100 and ramp 20 -> 100
        bus.sw_duty = 7'd127;
        wait_accept(20, cyc);
        check("clamp_target", bus.target, 100);
        cyc = 0;
        jumps = 0;
        prev = bus.duty_out;
        while (bus.busy && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (bus.duty_out != prev && bus.duty_out != prev + 7'd1) jumps++;
            prev = bus.duty_out;
        end
        check("clamp_cycles", cyc, RAMP ? 241 : 1);
        check("clamp_duty", bus.duty_out, 100);
        check("clamp_busy", bus.busy, 0);
        check("clamp_jumps", jumps, RAMP ? 0 : 1);
        // down to 0, then reversal while heading for 30
        bus.sw_duty = 7'd0;
        wait_accept(20, cyc);
        wait_idle(400);
        check("zero_duty", bus.duty_out, 0);
        bus.sw_duty = 7'd30;
        wait_accept(20, cyc);
        wait_duty(RAMP ? 7'd10 : 7'd30, 100);
        bus.sw_duty = 7'd5;
        dmax = bus.duty_out;
        dmin = bus.duty_out;
        cyc = 0;
        while (!(bus.target == 7'd5 && !bus.busy) && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.duty_out > dmax) dmax = bus.duty_out;
            if (bus.duty_out < dmin) dmin = bus.duty_out;
        end
        check("rev_target", bus.target, 5);
        check("rev_max", dmax, RAMP ? 12 : 30);
        check("rev_min", dmin, 5);
        repeat (5) @(negedge clk);
        check("rev_hold_duty", bus.duty_out, 5);
        check("rev_hold_busy", bus.busy, 0);
        // asynchronous reset while duty_out reads 37
        bus.sw_duty = RAMP ? 7'd60 : 7'd37;
        wait_accept(20, cyc);
        wait_duty(7'd37, 300);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_duty", bus.duty_out, 0);
        check("async_rst_target", bus.target, 0);
        check("async_rst_busy", bus.busy, 0);
        // fresh start from 0, jump to 80
        bus.sw_duty = 7'd0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_no_accept", bus.target, 0);
        bus.sw_duty = 7'd80;
        wait_accept(20, cyc);
        check("j80_lat", cyc, 7);
        check("j80_target", bus.target, 80);
        check("j80_duty_lag", bus.duty_out, 0);
        bcnt = 0;
        repeat (10) begin
            bcnt += int'(bus.busy);
            @(negedge clk);
        end
        check("j80_busy_len", bcnt, RAMP ? 10 : 1);
        check("j80_duty", bus.duty_out, RAMP ? 3 : 80);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
